// File: rtl/benes_stage_pipe.sv
// Registered Benes/butterfly stage with a strided 2x2 switch layer, a two-slot
// configuration queue (active + pending) and a single valid/ready pipeline register.
module benes_stage_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int SIZE       = 32,
  parameter int STRIDE     = 1,
  parameter int BEAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SIZE-1:0]       cfg_mode,
  input  logic [BEAT_W-1:0]     cfg_beats,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [0:SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:SIZE-1],
  output logic                  out_cfg_last
);

  localparam int SWITCH_NUM = SIZE / 2;

  logic                  active_full_q, active_full_d;
  logic [SIZE-1:0]       active_mode_q, active_mode_d;
  logic [BEAT_W-1:0]     beats_left_q, beats_left_d;
  logic                  pending_full_q, pending_full_d;
  logic [SIZE-1:0]       pending_mode_q, pending_mode_d;
  logic [BEAT_W-1:0]     pending_beats_q, pending_beats_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_cfg_last_q, out_cfg_last_d;
  logic [DATA_WIDTH-1:0] out_data_q [0:SIZE-1];
  logic [DATA_WIDTH-1:0] out_data_d [0:SIZE-1];
  logic [DATA_WIDTH-1:0] switched [0:SIZE-1];
  logic                  in_fire;
  logic                  cfg_fire;
  logic [BEAT_W-1:0]     cfg_beats_eff;

  // Each switch owns exactly one (lo, hi) lane pair, so every switched lane has one driver.
  for (genvar k = 0; k < SWITCH_NUM; k++) begin : g_sw
    localparam int LO = (k / STRIDE) * 2 * STRIDE + (k % STRIDE);
    localparam int HI = LO + STRIDE;
    logic [1:0] mode;
    assign mode         = active_mode_q[2*k +: 2];
    assign switched[LO] = mode[0] ? in_data[HI] : in_data[LO];
    assign switched[HI] = (mode[1] == mode[0]) ? in_data[HI] : in_data[LO];
  end

  assign in_ready      = active_full_q && (!out_valid_q || out_ready);
  assign in_fire       = in_valid && in_ready;
  assign cfg_fire      = cfg_valid && cfg_ready_q;
  assign cfg_beats_eff = (cfg_beats == '0) ? BEAT_W'(1) : cfg_beats;

  always_comb begin
    active_full_d   = active_full_q;
    active_mode_d   = active_mode_q;
    beats_left_d    = beats_left_q;
    pending_full_d  = pending_full_q;
    pending_mode_d  = pending_mode_q;
    pending_beats_d = pending_beats_q;
    out_valid_d     = out_valid_q;
    out_cfg_last_d  = out_cfg_last_q;
    out_data_d      = out_data_q;

    if (in_fire) begin
      out_data_d     = switched;
      out_valid_d    = 1'b1;
      out_cfg_last_d = (beats_left_q == BEAT_W'(1));
      if (beats_left_q == BEAT_W'(1)) begin
        if (pending_full_q) begin
          active_mode_d  = pending_mode_q;
          beats_left_d   = pending_beats_q;
          pending_full_d = 1'b0;
        end else begin
          active_full_d = 1'b0;
          beats_left_d  = '0;
        end
      end else begin
        beats_left_d = beats_left_q - BEAT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d    = 1'b0;
      out_cfg_last_d = 1'b0;
    end

    // Placement looks at the post-beat active slot, so a config arriving as the
    // last beat retires (with nothing pending) goes straight to active.
    if (cfg_fire) begin
      if (!active_full_d) begin
        active_full_d = 1'b1;
        active_mode_d = cfg_mode;
        beats_left_d  = cfg_beats_eff;
      end else begin
        pending_full_d  = 1'b1;
        pending_mode_d  = cfg_mode;
        pending_beats_d = cfg_beats_eff;
      end
    end

    cfg_ready_d = !pending_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_full_q   <= 1'b0;
      active_mode_q   <= '0;
      beats_left_q    <= '0;
      pending_full_q  <= 1'b0;
      pending_mode_q  <= '0;
      pending_beats_q <= '0;
      cfg_ready_q     <= 1'b1;
      out_valid_q     <= 1'b0;
      out_cfg_last_q  <= 1'b0;
      for (int i = 0; i < SIZE; i++) out_data_q[i] <= '0;
    end else begin
      active_full_q   <= active_full_d;
      active_mode_q   <= active_mode_d;
      beats_left_q    <= beats_left_d;
      pending_full_q  <= pending_full_d;
      pending_mode_q  <= pending_mode_d;
      pending_beats_q <= pending_beats_d;
      cfg_ready_q     <= cfg_ready_d;
      out_valid_q     <= out_valid_d;
      out_cfg_last_q  <= out_cfg_last_d;
      out_data_q      <= out_data_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign out_valid    = out_valid_q;
  assign out_cfg_last = out_cfg_last_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_benes_stage_pipe.sv
// Bench for benes_stage_pipe: two 8-lane instances (stride 1 and stride 2) share stimulus
// and are compared each cycle against a transaction-level queue model.
module tb_benes_stage_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_mode;
  logic [7:0] cfg_beats;
  logic       in_valid;
  logic [3:0] in_data [0:7];
  logic       out_ready;

  logic       cfg_ready_a, in_ready_a, out_valid_a, out_last_a;
  logic [3:0] out_data_a [0:7];
  logic       cfg_ready_b, in_ready_b, out_valid_b, out_last_b;
  logic [3:0] out_data_b [0:7];

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [7:0] mode;
    int         left;
  } cfg_t;

  cfg_t        cfg_q[$];
  bit          m_valid, m_last;
  logic [31:0] m_data_a, m_data_b;

  always #5 clk = ~clk;

  benes_stage_pipe #(.DATA_WIDTH(4), .SIZE(8), .STRIDE(1), .BEAT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .cfg_mode(cfg_mode), .cfg_beats(cfg_beats), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_cfg_last(out_last_a)
  );

  benes_stage_pipe #(.DATA_WIDTH(4), .SIZE(8), .STRIDE(2), .BEAT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .cfg_mode(cfg_mode), .cfg_beats(cfg_beats), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_data(in_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_cfg_last(out_last_b)
  );

  function automatic logic [31:0] packLanes(input logic [3:0] lanes [0:7]);
    logic [31:0] r;
    for (int j = 0; j < 8; j++) r[4*j +: 4] = lanes[j];
    return r;
  endfunction

  // Lane-centric reference: find each output lane's pair and pick its source lane.
  function automatic logic [31:0] refSwitch(input logic [31:0] din, input logic [7:0] mode,
                                            input int stride);
    logic [31:0] r;
    int off, k, lo, hi, src;
    logic [1:0] m;
    for (int j = 0; j < 8; j++) begin
      off = j % (2 * stride);
      k   = (j / (2 * stride)) * stride + (off % stride);
      m   = mode[2*k +: 2];
      lo  = (off >= stride) ? j - stride : j;
      hi  = lo + stride;
      case (m)
        2'd0:    src = j;
        2'd1:    src = (j == lo) ? hi : lo;
        2'd2:    src = lo;
        default: src = hi;
      endcase
      r[4*j +: 4] = din[4*src +: 4];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    cfg_q.delete();
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data_a = '0;
    m_data_b = '0;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic applyStimulus(input bit cv, input logic [7:0] cm, input logic [7:0] cb,
                               input bit iv, input logic [31:0] din, input bit ordy);
    bit   exp_cfg_ready, exp_in_ready, in_fire, cfg_fire;
    cfg_t head, c;
    cfg_valid = cv;
    cfg_mode  = cm;
    cfg_beats = cb;
    in_valid  = iv;
    for (int j = 0; j < 8; j++) in_data[j] = din[4*j +: 4];
    out_ready = ordy;
    @(negedge clk);
    exp_cfg_ready = (cfg_q.size() < 2);
    exp_in_ready  = (cfg_q.size() > 0) && (!m_valid || ordy);
    checkOutput("cfg_ready_a", 32'(cfg_ready_a), 32'(exp_cfg_ready));
    checkOutput("cfg_ready_b", 32'(cfg_ready_b), 32'(exp_cfg_ready));
    checkOutput("in_ready_a", 32'(in_ready_a), 32'(exp_in_ready));
    checkOutput("in_ready_b", 32'(in_ready_b), 32'(exp_in_ready));
    checkOutput("out_valid_a", 32'(out_valid_a), 32'(m_valid));
    checkOutput("out_valid_b", 32'(out_valid_b), 32'(m_valid));
    checkOutput("out_last_a", 32'(out_last_a), 32'(m_last));
    checkOutput("out_last_b", 32'(out_last_b), 32'(m_last));
    checkOutput("out_data_a", packLanes(out_data_a), m_data_a);
    checkOutput("out_data_b", packLanes(out_data_b), m_data_b);
    in_fire  = iv && exp_in_ready;
    cfg_fire = cv && exp_cfg_ready;
    if (in_fire) begin
      head     = cfg_q[0];
      m_data_a = refSwitch(din, head.mode, 1);
      m_data_b = refSwitch(din, head.mode, 2);
      m_last   = (head.left == 1);
      m_valid  = 1'b1;
      head.left = head.left - 1;
      if (head.left == 0) void'(cfg_q.pop_front());
      else cfg_q[0] = head;
    end else if (ordy) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
    if (cfg_fire) begin
      c.mode = cm;
      c.left = (cb == 0) ? 1 : int'(cb);
      cfg_q.push_back(c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_mode = '0; cfg_beats = '0; in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 8; j++) in_data[j] = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready_a), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready_a), 32'd0);
    checkOutput("rst_out_data", packLanes(out_data_b), 32'd0);
    rst = 1'b0;

    // No configuration loaded: beats must be refused.
    repeat (3) applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
    checkOutput("nocfg_in_ready", 32'(in_ready_a), 32'd0);
    checkOutput("nocfg_out_valid", 32'(out_valid_b), 32'd0);

    // Pass/cross on switch 0 only.
    applyStimulus(1, 8'h01, 8'd1, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'h76543210, 1);
    checkOutput("pc_data_s1", packLanes(out_data_a), 32'h76543201);
    checkOutput("pc_data_s2", packLanes(out_data_b), 32'h76543012);
    checkOutput("pc_last", 32'(out_last_a), 32'd1);
    checkOutput("pc_in_ready", 32'(in_ready_a), 32'd0);

    // Broadcast-lo then broadcast-hi on all switches.
    applyStimulus(1, 8'hAA, 8'd1, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'h76543210, 1);
    checkOutput("bclo_s1", packLanes(out_data_a), 32'h66442200);
    checkOutput("bclo_s2", packLanes(out_data_b), 32'h54541010);
    applyStimulus(1, 8'hFF, 8'd1, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'h76543210, 1);
    checkOutput("bchi_s1", packLanes(out_data_a), 32'h77553311);
    checkOutput("bchi_s2", packLanes(out_data_b), 32'h76763232);
    applyStimulus(0, 8'h00, 8'd0, 0, 32'h0, 1);

    // Back-to-back configurations: pass x3 then cross x2.
    applyStimulus(1, 8'h00, 8'd3, 0, 32'h0, 1);
    applyStimulus(1, 8'h55, 8'd2, 1, $urandom, 1);
    checkOutput("b2b_cfg_ready_low", 32'(cfg_ready_a), 32'd0);
    repeat (4) applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
    checkOutput("b2b_last_beat5", 32'(out_last_b), 32'd1);
    applyStimulus(0, 8'h00, 8'd0, 0, 32'h0, 1);

    // Backpressure: output held for four cycles, then released with a beat waiting.
    applyStimulus(1, 8'h5A, 8'd2, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'hFEDCBA98, 1);
    repeat (4) applyStimulus(0, 8'h00, 8'd0, 1, 32'h13572468, 0);
    checkOutput("bp_in_ready", 32'(in_ready_a), 32'd0);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'h13572468, 1);
    applyStimulus(0, 8'h00, 8'd0, 0, 32'h0, 1);

    // cfg_beats of zero behaves as a single beat.
    applyStimulus(1, 8'h0F, 8'd0, 0, 32'h0, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
    checkOutput("zero_beats_last", 32'(out_last_a), 32'd1);
    applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
    checkOutput("zero_beats_one", 32'(out_valid_a), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) == 0, 8'($urandom), 8'($urandom_range(0, 4)),
                    ($urandom % 4) != 0, $urandom, ($urandom % 4) != 0);

    guard = 0;
    while ((cfg_q.size() > 0 || m_valid) && guard < 100) begin
      applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
      guard++;
    end
    checkOutput("drain_done", 32'(guard < 100), 32'd1);

    // Asynchronous reset with a held output beat and a full pending slot.
    applyStimulus(1, 8'h00, 8'd3, 0, 32'h0, 1);
    applyStimulus(1, 8'h55, 8'd2, 1, 32'h76543210, 1);
    applyStimulus(0, 8'h00, 8'd0, 1, 32'h0, 0);
    checkOutput("pre_rst_valid", 32'(out_valid_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready_b), 32'd0);
    checkOutput("arst_out_data", packLanes(out_data_a), 32'd0);
    resetModel();
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post_rst_cfg_ready", 32'(cfg_ready_a), 32'd1);
    repeat (2) applyStimulus(0, 8'h00, 8'd0, 1, $urandom, 1);
    checkOutput("post_rst_out_valid", 32'(out_valid_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
